// File: rtl/perceptron_uart_pkg.sv
// Shared definitions for the perceptron UART command receiver and result framer.
package perceptron_uart_pkg;

    localparam logic [7:0] FRAME_HEADER = 8'hA5;

    // Framer sequencing states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_PAYLOAD,
        ST_CHECKSUM,
        ST_DONE
    } frame_state_t;

    // Byte serializer states.
    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    // Clock cycles per UART bit; truncation is intentional.
    function automatic int calc_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    // Bytes needed to carry a W-bit result.
    function automatic int payload_bytes(input int width);
        return (width + 7) / 8;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer. Accepts a new byte while idle or in the last cycle of
// its stop bit, so consecutive bytes go out with no gap on the line.
module uart_tx_byte
    import perceptron_uart_pkg::*;
#(
    parameter int DIV = 1250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_ready,
    output logic       tx
);

    localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV - 1);

    tx_state_t        state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [7:0]       shifter, shifter_n;
    logic             tx_q, tx_n;

    assign tx = tx_q;

    // State and line register; reset forces the line idle without a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= TX_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shifter <= '0;
            tx_q    <= 1'b1;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            shifter <= shifter_n;
            tx_q    <= tx_n;
        end
    end

    // Bit timing: down-counter reloads at every bit boundary.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        bit_idx_n  = bit_idx;
        shifter_n  = shifter;
        tx_n       = tx_q;
        byte_ready = (state == TX_IDLE) || ((state == TX_STOP) && (cnt == '0));

        case (state)
            TX_IDLE: begin
                tx_n = 1'b1;
            end
            TX_START: begin
                if (cnt == '0) begin
                    state_n   = TX_DATA;
                    cnt_n     = CNT_LOAD;
                    bit_idx_n = '0;
                    tx_n      = shifter[0];
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            TX_DATA: begin
                if (cnt == '0) begin
                    cnt_n = CNT_LOAD;
                    if (bit_idx == 3'd7) begin
                        state_n = TX_STOP;
                        tx_n    = 1'b1;
                    end else begin
                        bit_idx_n = bit_idx + 1'b1;
                        shifter_n = shifter >> 1;
                        tx_n      = shifter[1];
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            TX_STOP: begin
                if (cnt == '0) begin
                    state_n = TX_IDLE;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            default: begin
                state_n = TX_IDLE;
                tx_n    = 1'b1;
            end
        endcase

        if (byte_valid && byte_ready) begin
            state_n   = TX_START;
            cnt_n     = CNT_LOAD;
            bit_idx_n = '0;
            shifter_n = byte_data;
            tx_n      = 1'b0;
        end
    end

endmodule

// File: rtl/perceptron_result_tx.sv
// Result framer: header A5, sign-extended result MSB byte first, XOR checksum.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | waiting for a result; result_ready high
// ST_HEADER   | offering the header byte to the serializer
// ST_PAYLOAD  | offering payload byte idx (0 = most significant)
// ST_CHECKSUM | offering checksum, then waiting for its stop bit to end
// ST_DONE     | one-cycle frame_done; may accept the next result
module perceptron_result_tx
    import perceptron_uart_pkg::*;
#(
    parameter int fp_integer_width = 4,
    parameter int fp_fract_width   = 4,
    parameter int clock_frequency  = 12000000,
    parameter int uart_baud_rate   = 9600
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       result_valid,
    input  logic [fp_integer_width+fp_fract_width-1:0] result,
    output logic                                       result_ready,
    output logic                                       busy,
    output logic                                       frame_done,
    output logic                                       tx
);

    localparam int W     = fp_integer_width + fp_fract_width;
    localparam int DIV   = calc_div(clock_frequency, uart_baud_rate);
    localparam int P     = payload_bytes(W);
    localparam int XW    = 8 * P;
    localparam int IDX_W = (P > 1) ? $clog2(P) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(P - 1);

    frame_state_t     state, state_n;
    logic [W-1:0]     res_q, res_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic [7:0]       chk, chk_n;
    logic             chk_sent, chk_sent_n;

    logic             byte_valid;
    logic [7:0]       byte_data;
    logic             byte_ready;

    logic [XW-1:0]    ext;
    logic [7:0]       lsb_bytes [2**IDX_W];
    logic [7:0]       pay_byte;

    assign ext = XW'($signed(res_q));

    // Split the extended result into bytes, index 0 = least significant.
    always_comb begin
        for (int i = 0; i < 2**IDX_W; i++) begin
            lsb_bytes[i] = 8'h00;
        end
        for (int i = 0; i < P; i++) begin
            lsb_bytes[i] = ext[8*i +: 8];
        end
        pay_byte = lsb_bytes[LAST_IDX - idx];
    end

    // Framer state and held result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            res_q    <= '0;
            idx      <= '0;
            chk      <= '0;
            chk_sent <= 1'b0;
        end else begin
            state    <= state_n;
            res_q    <= res_n;
            idx      <= idx_n;
            chk      <= chk_n;
            chk_sent <= chk_sent_n;
        end
    end

    // Next-state, byte selection and status outputs.
    always_comb begin
        state_n      = state;
        res_n        = res_q;
        idx_n        = idx;
        chk_n        = chk;
        chk_sent_n   = chk_sent;
        byte_valid   = 1'b0;
        byte_data    = FRAME_HEADER;
        result_ready = 1'b0;
        busy         = 1'b1;
        frame_done   = 1'b0;

        case (state)
            ST_IDLE: begin
                result_ready = 1'b1;
                busy         = 1'b0;
                if (result_valid) begin
                    res_n   = result;
                    state_n = ST_HEADER;
                end
            end
            ST_HEADER: begin
                byte_valid = 1'b1;
                byte_data  = FRAME_HEADER;
                if (byte_ready) begin
                    state_n = ST_PAYLOAD;
                    idx_n   = '0;
                    chk_n   = FRAME_HEADER;
                end
            end
            ST_PAYLOAD: begin
                byte_valid = 1'b1;
                byte_data  = pay_byte;
                if (byte_ready) begin
                    chk_n = chk ^ pay_byte;
                    if (idx == LAST_IDX) begin
                        state_n    = ST_CHECKSUM;
                        chk_sent_n = 1'b0;
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end
            end
            ST_CHECKSUM: begin
                if (!chk_sent) begin
                    byte_valid = 1'b1;
                    byte_data  = chk;
                    if (byte_ready) begin
                        chk_sent_n = 1'b1;
                    end
                end else if (byte_ready) begin
                    // Serializer is in the last stop-bit cycle of the checksum.
                    chk_sent_n = 1'b0;
                    state_n    = ST_DONE;
                end
            end
            ST_DONE: begin
                frame_done   = 1'b1;
                result_ready = 1'b1;
                busy         = 1'b0;
                if (result_valid) begin
                    // Serializer is idle here, so the header is handed over
                    // directly; the line gap between frames stays one cycle.
                    res_n      = result;
                    byte_valid = 1'b1;
                    byte_data  = FRAME_HEADER;
                    chk_n      = FRAME_HEADER;
                    idx_n      = '0;
                    state_n    = ST_PAYLOAD;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    uart_tx_byte #(
        .DIV(DIV)
    ) u_tx_byte (
        .clk        (clk),
        .rst        (rst),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .tx         (tx)
    );

endmodule
